// File: rtl/munoc_ahb_quiesce_ctrl_pkg.sv
// Shared AHB encodings, quiesce FSM states and burst helpers
// for the munoc AHB quiesce controller.
package munoc_ahb_quiesce_ctrl_pkg;

    localparam int BW_AHB_TRANS = 2;
    localparam int BW_AHB_BURST = 3;
    localparam int BW_BEAT      = 4;

    localparam logic [BW_AHB_TRANS-1:0] AHB_TRANS_IDLE   = 2'd0;
    localparam logic [BW_AHB_TRANS-1:0] AHB_TRANS_BUSY   = 2'd1;
    localparam logic [BW_AHB_TRANS-1:0] AHB_TRANS_NONSEQ = 2'd2;
    localparam logic [BW_AHB_TRANS-1:0] AHB_TRANS_SEQ    = 2'd3;

    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_SINGLE = 3'd0;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_INCR   = 3'd1;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_WRAP4  = 3'd2;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_INCR4  = 3'd3;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_WRAP8  = 3'd4;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_INCR8  = 3'd5;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_WRAP16 = 3'd6;
    localparam logic [BW_AHB_BURST-1:0] AHB_BURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        QSC_RUN     = 2'd0,
        QSC_DRAIN   = 2'd1,
        QSC_BLOCKED = 2'd2
    } qsc_state_e;

    // Remaining beats after the NONSEQ beat of a burst.
    function automatic logic [BW_BEAT-1:0] burst_to_beats(
        input logic [BW_AHB_BURST-1:0] hburst
    );
        case (hburst)
            AHB_BURST_WRAP4,  AHB_BURST_INCR4:  return 4'd3;
            AHB_BURST_WRAP8,  AHB_BURST_INCR8:  return 4'd7;
            AHB_BURST_WRAP16, AHB_BURST_INCR16: return 4'd15;
            default:                            return 4'd0;
        endcase
    endfunction

    function automatic logic burst_is_fixed(
        input logic [BW_AHB_BURST-1:0] hburst
    );
        return (hburst != AHB_BURST_SINGLE) && (hburst != AHB_BURST_INCR);
    endfunction

endpackage

// File: rtl/munoc_ahb_burst_tracker.sv
// Tracks beats left in a fixed-length burst on the gated bus
// and flags sticky protocol violations.
module munoc_ahb_burst_tracker
    import munoc_ahb_quiesce_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic [BW_AHB_TRANS-1:0] mon_htrans,
    input  logic [BW_AHB_BURST-1:0] mon_hburst,
    input  logic                    mon_hready,
    input  logic                    mon_hresp,
    output logic [BW_BEAT-1:0]      beat_cnt,
    output logic                    burst_active,
    output logic                    protocol_err
);

    logic [BW_BEAT-1:0] beat_cnt_q, beat_cnt_d;
    logic               perr_q, perr_d;
    logic               prev_err_q, prev_err_d;

    // Beat counter and violation detection from accepted addresses.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        perr_d     = perr_q;
        prev_err_d = mon_hready ? mon_hresp : prev_err_q;
        if (mon_hready) begin
            case (mon_htrans)
                AHB_TRANS_NONSEQ: beat_cnt_d = burst_to_beats(mon_hburst);
                AHB_TRANS_SEQ: begin
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end else if (burst_is_fixed(mon_hburst)) begin
                        perr_d = 1'b1;
                    end
                end
                AHB_TRANS_IDLE: begin
                    beat_cnt_d = '0;
                    if (beat_cnt_q != '0 && !mon_hresp && !prev_err_q) begin
                        perr_d = 1'b1;
                    end
                end
                default: beat_cnt_d = beat_cnt_q;
            endcase
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            beat_cnt_q <= '0;
            perr_q     <= 1'b0;
            prev_err_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            perr_q     <= perr_d;
            prev_err_q <= prev_err_d;
        end
    end

    assign beat_cnt     = beat_cnt_q;
    assign burst_active = (beat_cnt_q != '0);
    assign protocol_err = perr_q;

endmodule

// File: rtl/munoc_ahb_quiesce_ctrl.sv
// Raises the registered AHB gate block only at a safe bus point
// and answers the stop_req/stop_ack quiesce handshake.
module munoc_ahb_quiesce_ctrl
    import munoc_ahb_quiesce_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int BW_CNT         = 9
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    stop_req,
    output logic                    stop_ack,
    output logic                    block,
    input  logic [BW_AHB_TRANS-1:0] mon_htrans,
    input  logic [BW_AHB_BURST-1:0] mon_hburst,
    input  logic                    mon_hready,
    input  logic                    mon_hresp,
    output logic                    burst_active,
    output logic                    drain_timeout,
    output logic                    protocol_err
);

    localparam logic [BW_CNT-1:0] TMO_LIMIT = BW_CNT'(TIMEOUT_CYCLES);
    localparam logic              TMO_EN    = (TIMEOUT_CYCLES != 0);

    qsc_state_e         state_q, state_d;
    logic [BW_CNT-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic               block_q, block_d;
    logic [BW_BEAT-1:0] beat_cnt;
    logic               safe;

    munoc_ahb_burst_tracker u_tracker (
        .clk          (clk),
        .rstnn        (rstnn),
        .mon_htrans   (mon_htrans),
        .mon_hburst   (mon_hburst),
        .mon_hready   (mon_hready),
        .mon_hresp    (mon_hresp),
        .beat_cnt     (beat_cnt),
        .burst_active (burst_active),
        .protocol_err (protocol_err)
    );

    // Last data phase ends this cycle and nothing is pending.
    assign safe = mon_hready && (mon_htrans == AHB_TRANS_IDLE)
               && (beat_cnt == '0);

    // Next state, drain timeout and block request.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        unique case (state_q)
            QSC_RUN: begin
                tmo_cnt_d = '0;
                if (stop_req) state_d = QSC_DRAIN;
            end
            QSC_DRAIN: begin
                if (!stop_req) begin
                    state_d = QSC_RUN;
                end else if (safe) begin
                    state_d = QSC_BLOCKED;
                end else begin
                    if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (TMO_EN && tmo_cnt_q == TMO_LIMIT) tmo_flag_d = 1'b1;
                end
            end
            QSC_BLOCKED: begin
                if (!stop_req) state_d = QSC_RUN;
            end
            default: state_d = QSC_RUN;
        endcase
        if (state_d == QSC_RUN && state_q != QSC_RUN) tmo_flag_d = 1'b0;
        block_d = (state_d == QSC_BLOCKED);
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q    <= QSC_RUN;
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
            block_q    <= block_d;
        end
    end

    assign block         = block_q;
    assign stop_ack      = block_q;
    assign drain_timeout = tmo_flag_q;

endmodule

// File: tb/tb_munoc_ahb_quiesce_ctrl.sv
// Scenario bench for munoc_ahb_quiesce_ctrl.
// Expected flags queued per driven cycle, checked after the edge.
module tb_munoc_ahb_quiesce_ctrl;
    import munoc_ahb_quiesce_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rstnn;
    logic       stop_req;
    logic       stop_ack, block;
    logic [1:0] mon_htrans;
    logic [2:0] mon_hburst;
    logic       mon_hready, mon_hresp;
    logic       burst_active, drain_timeout, protocol_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       sr;
        logic [1:0] ht;
        logic [2:0] hb;
        logic       hr;
        logic       hs;
        logic [4:0] ex;
    } step_t;

    logic [4:0] sb[$];

    munoc_ahb_quiesce_ctrl #(
        .TIMEOUT_CYCLES(4),
        .BW_CNT(9)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .stop_req      (stop_req),
        .stop_ack      (stop_ack),
        .block         (block),
        .mon_htrans    (mon_htrans),
        .mon_hburst    (mon_hburst),
        .mon_hready    (mon_hready),
        .mon_hresp     (mon_hresp),
        .burst_active  (burst_active),
        .drain_timeout (drain_timeout),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    // {block, stop_ack, drain_timeout, protocol_err, burst_active}
    function automatic logic [4:0] obs();
        return {block, stop_ack, drain_timeout, protocol_err, burst_active};
    endfunction

    function automatic step_t mk(input logic sr, input logic [1:0] ht,
                                 input logic [2:0] hb, input logic hr,
                                 input logic hs, input logic [4:0] ex);
        step_t s;
        s.sr = sr; s.ht = ht; s.hb = hb; s.hr = hr; s.hs = hs; s.ex = ex;
        return s;
    endfunction

    task automatic apply(input step_t s);
        stop_req   = s.sr;
        mon_htrans = s.ht;
        mon_hburst = s.hb;
        mon_hready = s.hr;
        mon_hresp  = s.hs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        rstnn = 1'b0;
        apply(mk(1, AHB_TRANS_NONSEQ, AHB_BURST_INCR8, 1, 0, 5'b00000));
        sb.push_back(5'b00000);
        apply(mk(1, AHB_TRANS_NONSEQ, AHB_BURST_INCR8, 1, 0, 5'b00000));
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", obs(), e);
        end
        rstnn = 1'b1;
    endtask

    task automatic test_idle_stop();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL idle_stop step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_incr8_drain();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(0, AHB_TRANS_NONSEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL incr8_drain step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_wait_states();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(1, AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 0, 0, 5'b00000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 0, 0, 5'b00100));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 0, 0, 5'b00100));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11100));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL wait_states step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_timeout();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(1, AHB_TRANS_NONSEQ, AHB_BURST_INCR, 1, 0, 5'b00000));
        for (int k = 1; k <= 10; k++) begin
            st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR, 1, 0,
                            (k >= 5) ? 5'b00100 : 5'b00000));
        end
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11100));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_stop_pulse();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(0, AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(1, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_BUSY, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL stop_pulse step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_error_exempt();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(0, AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 0, 1, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 1, 5'b00000));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR4, 1, 0, 5'b00010));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00010));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL error_exempt step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_perr_and_reset_blocked();
        step_t st[$];
        logic [4:0] e;
        rstnn = 1'b0;
        sb.push_back(5'b00000);
        apply(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        rstnn = 1'b1;
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL perr_clear_by_reset: got %b want %b", obs(), e);
        end
        st.push_back(mk(0, AHB_TRANS_NONSEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_SEQ, AHB_BURST_INCR8, 1, 0, 5'b00001));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00010));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00010));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00010));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11010));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL perr_blocked step %0d: got %b want %b", i, obs(), e);
            end
        end
        rstnn = 1'b0;
        sb.push_back(5'b00000);
        apply(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        rstnn = 1'b1;
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_in_blocked: got %b want %b", obs(), e);
        end
        st = {};
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        st.push_back(mk(1, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b11000));
        st.push_back(mk(0, AHB_TRANS_IDLE, AHB_BURST_SINGLE, 1, 0, 5'b00000));
        foreach (st[i]) begin
            sb.push_back(st[i].ex);
            apply(st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL post_reset step %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    initial begin
        rstnn      = 1'b0;
        stop_req   = 1'b0;
        mon_htrans = AHB_TRANS_IDLE;
        mon_hburst = AHB_BURST_SINGLE;
        mon_hready = 1'b1;
        mon_hresp  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_idle_stop();
        test_incr8_drain();
        test_wait_states();
        test_timeout();
        test_stop_pulse();
        test_error_exempt();
        test_perr_and_reset_blocked();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
